// File: rtl/axi_cmd_pkt_decoder_if.sv
// FIFO pop port and AXI AW/W/AR channels of the command-packet decoder.
// The master modport is the decoder side; the slave modport is the FIFO/AXI side.
interface axi_cmd_pkt_decoder_if #(
   parameter int FIFO_W = 128,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int ID_W   = 4,
   parameter int LEN_W  = 8
);
   logic                fifo_empty;
   logic                fifo_rd_en;
   logic [FIFO_W-1:0]   fifo_rdata;

   logic                awvalid;
   logic                awready;
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [LEN_W-1:0]    awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awlock;
   logic [3:0]          awcache;
   logic [2:0]          awprot;

   logic                wvalid;
   logic                wready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;

   logic                arvalid;
   logic                arready;
   logic [ID_W-1:0]     arid;
   logic [ADDR_W-1:0]   araddr;
   logic [LEN_W-1:0]    arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arlock;
   logic [3:0]          arcache;
   logic [2:0]          arprot;

   logic                pkt_err;

   modport master (
      input  fifo_empty, fifo_rdata, awready, wready, arready,
      output fifo_rd_en,
      output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
      output wvalid, wdata, wstrb, wlast,
      output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
      output pkt_err
   );

   modport slave (
      output fifo_empty, fifo_rdata, awready, wready, arready,
      input  fifo_rd_en,
      input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
      input  wvalid, wdata, wstrb, wlast,
      input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
      input  pkt_err
   );
endinterface

// File: rtl/axi_cmd_pkt_decoder.sv
// Pops framed command packets from the host FIFO, decodes AW/AR headers and
// unpacks write data words into len+1 W beats; malformed headers are dropped.
module axi_cmd_pkt_decoder #(
   parameter int FIFO_W = 128,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int ID_W   = 4,
   parameter int LEN_W  = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   axi_cmd_pkt_decoder_if.master bus
);
   localparam int STRB_W  = DATA_W / 8;
   localparam int SLICES  = FIFO_W / DATA_W;
   localparam int SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam int CNT_W   = LEN_W + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR    = 3'd1,
      S_AW     = 3'd2,
      S_AR     = 3'd3,
      S_DFETCH = 3'd4,
      S_DLOAD  = 3'd5,
      S_BEATS  = 3'd6
   } state_t;

   // Field order matches the header bit order, so one slice decodes all of it.
   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic [2:0]        size;
      logic [1:0]        burst;
      logic              lock;
      logic [3:0]        cache;
      logic [2:0]        prot;
   } ax_t;

   localparam int AX_W     = $bits(ax_t);
   localparam int AX_LSB   = FIFO_W - 16 - AX_W;
   localparam int STRB_LSB = AX_LSB - STRB_W;

   localparam logic [7:0]         SOP_BYTE   = 8'hAA;
   localparam logic [7:0]         TYP_WR     = 8'h01;
   localparam logic [7:0]         TYP_RD     = 8'h02;
   localparam logic [CNT_W-1:0]   ONE_BEAT   = CNT_W'(1);
   localparam logic [CNT_W-1:0]   TWO_BEATS  = CNT_W'(2);
   localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(SLICES - 1);

   state_t              state_q, state_d;
   ax_t                 aw_q, aw_d, ar_q, ar_d;
   logic                awvalid_q, awvalid_d, arvalid_q, arvalid_d;
   logic                wvalid_q, wvalid_d, wlast_q, wlast_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [FIFO_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]    remaining_q, remaining_d;
   logic [SLICE_W-1:0]  slice_q, slice_d;

   logic [7:0]          hdr_sop;
   logic [7:0]          hdr_typ;
   ax_t                 hdr_ax;
   logic [STRB_W-1:0]   hdr_strb;
   logic                hdr_bad;
   logic                pop;
   logic                pkt_err;

   assign hdr_sop  = bus.fifo_rdata[FIFO_W-1 -: 8];
   assign hdr_typ  = bus.fifo_rdata[FIFO_W-9 -: 8];
   assign hdr_ax   = bus.fifo_rdata[AX_LSB +: AX_W];
   assign hdr_strb = bus.fifo_rdata[STRB_LSB +: STRB_W];
   assign hdr_bad  = (hdr_sop != SOP_BYTE) || ((hdr_typ != TYP_WR) && (hdr_typ != TYP_RD));

   // Next-state and next-output logic for the packet FSM.
   always_comb begin
      state_d     = state_q;
      aw_d        = aw_q;
      ar_d        = ar_q;
      awvalid_d   = awvalid_q;
      arvalid_d   = arvalid_q;
      wvalid_d    = wvalid_q;
      wlast_d     = wlast_q;
      wstrb_d     = wstrb_q;
      shift_d     = shift_q;
      remaining_d = remaining_q;
      slice_d     = slice_q;
      pop         = 1'b0;
      pkt_err     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!bus.fifo_empty) begin
               pop     = 1'b1;
               state_d = S_HDR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HDR: begin
            if (hdr_bad) begin
               pkt_err = 1'b1;
               state_d = S_IDLE;
            end else if (hdr_typ == TYP_WR) begin
               aw_d        = hdr_ax;
               awvalid_d   = 1'b1;
               wstrb_d     = hdr_strb;
               remaining_d = {1'b0, hdr_ax.len} + ONE_BEAT;
               state_d     = S_AW;
            end else begin
               ar_d      = hdr_ax;
               arvalid_d = 1'b1;
               state_d   = S_AR;
            end
         end
         S_AW: begin
            if (bus.awready) begin
               awvalid_d = 1'b0;
               state_d   = S_DFETCH;
            end else begin
               state_d   = S_AW;
            end
         end
         S_AR: begin
            if (bus.arready) begin
               arvalid_d = 1'b0;
               state_d   = S_IDLE;
            end else begin
               state_d   = S_AR;
            end
         end
         S_DFETCH: begin
            if (!bus.fifo_empty) begin
               pop     = 1'b1;
               state_d = S_DLOAD;
            end else begin
               state_d = S_DFETCH;
            end
         end
         S_DLOAD: begin
            shift_d  = bus.fifo_rdata;
            slice_d  = {SLICE_W{1'b0}};
            wvalid_d = 1'b1;
            wlast_d  = (remaining_q == ONE_BEAT);
            state_d  = S_BEATS;
         end
         S_BEATS: begin
            if (bus.wready) begin
               shift_d     = shift_q >> DATA_W;
               remaining_d = remaining_q - ONE_BEAT;
               slice_d     = slice_q + SLICE_W'(1);
               if (remaining_q == ONE_BEAT) begin
                  wvalid_d = 1'b0;
                  wlast_d  = 1'b0;
                  state_d  = S_IDLE;
               end else if (slice_q == LAST_SLICE) begin
                  // Word used up: unused upper slices of a final word never get here.
                  wvalid_d = 1'b0;
                  wlast_d  = 1'b0;
                  state_d  = S_DFETCH;
               end else begin
                  wlast_d  = (remaining_q == TWO_BEATS);
                  state_d  = S_BEATS;
               end
            end else begin
               state_d = S_BEATS;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state and all registered outputs; async reset discards any partial packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         aw_q        <= {AX_W{1'b0}};
         ar_q        <= {AX_W{1'b0}};
         awvalid_q   <= 1'b0;
         arvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         wlast_q     <= 1'b0;
         wstrb_q     <= {STRB_W{1'b0}};
         shift_q     <= {FIFO_W{1'b0}};
         remaining_q <= {CNT_W{1'b0}};
         slice_q     <= {SLICE_W{1'b0}};
      end else begin
         state_q     <= state_d;
         aw_q        <= aw_d;
         ar_q        <= ar_d;
         awvalid_q   <= awvalid_d;
         arvalid_q   <= arvalid_d;
         wvalid_q    <= wvalid_d;
         wlast_q     <= wlast_d;
         wstrb_q     <= wstrb_d;
         shift_q     <= shift_d;
         remaining_q <= remaining_d;
         slice_q     <= slice_d;
      end
   end

   // Pop is combinational so it can honour fifo_empty of the same cycle.
   assign bus.fifo_rd_en = pop & rst_n;
   assign bus.pkt_err    = pkt_err;

   assign bus.awvalid = awvalid_q;
   assign bus.awid    = aw_q.id;
   assign bus.awaddr  = aw_q.addr;
   assign bus.awlen   = aw_q.len;
   assign bus.awsize  = aw_q.size;
   assign bus.awburst = aw_q.burst;
   assign bus.awlock  = aw_q.lock;
   assign bus.awcache = aw_q.cache;
   assign bus.awprot  = aw_q.prot;

   assign bus.wvalid  = wvalid_q;
   assign bus.wdata   = shift_q[DATA_W-1:0];
   assign bus.wstrb   = wstrb_q;
   assign bus.wlast   = wlast_q;

   assign bus.arvalid = arvalid_q;
   assign bus.arid    = ar_q.id;
   assign bus.araddr  = ar_q.addr;
   assign bus.arlen   = ar_q.len;
   assign bus.arsize  = ar_q.size;
   assign bus.arburst = ar_q.burst;
   assign bus.arlock  = ar_q.lock;
   assign bus.arcache = ar_q.cache;
   assign bus.arprot  = ar_q.prot;
endmodule

// File: tb/tb_axi_cmd_pkt_decoder.sv
// Scoreboard bench for axi_cmd_pkt_decoder: a packet-level model queues the
// expected AW/AR/W/pkt_err traffic and a monitor compares every handshake.
module tb_axi_cmd_pkt_decoder;
   localparam int FIFO_W = 128;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int ID_W   = 4;
   localparam int LEN_W  = 8;
   localparam int STRB_W = DATA_W / 8;
   localparam int SLICES = FIFO_W / DATA_W;
   localparam int HDR_W  = 16 + ID_W + ADDR_W + LEN_W + 13 + STRB_W;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic [2:0]        size;
      logic [1:0]        burst;
      logic              lock;
      logic [3:0]        cache;
      logic [2:0]        prot;
   } ax_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
      logic              last;
   } w_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;
   bit   rand_mode = 1'b0;
   bit   ar_block  = 1'b0;

   ax_t               exp_aw[$];
   ax_t               exp_ar[$];
   w_t                exp_w[$];
   int                exp_err = 0;
   logic [FIFO_W-1:0] fifo_q[$];
   int                aw_hs_cyc[$];
   int                w_hs_cyc[$];

   axi_cmd_pkt_decoder_if #(.FIFO_W(FIFO_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                            .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

   axi_cmd_pkt_decoder #(.FIFO_W(FIFO_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                         .ID_W(ID_W), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: got %s", name, what);
   endtask

   function automatic logic [255:0] all_out();
      return 256'({bus.fifo_rd_en, bus.pkt_err,
                   bus.awvalid, bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst,
                   bus.awlock, bus.awcache, bus.awprot,
                   bus.wvalid, bus.wdata, bus.wstrb, bus.wlast,
                   bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst,
                   bus.arlock, bus.arcache, bus.arprot});
   endfunction

   function automatic logic [FIFO_W-1:0] junk();
      logic [FIFO_W-1:0] v;
      v = '0;
      for (int i = 0; i < FIFO_W; i += 32) v[i +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [FIFO_W-1:0] mk_hdr(input logic [7:0] sop, input logic [7:0] typ,
                                                input ax_t ax, input logic [STRB_W-1:0] strb);
      logic [HDR_W-1:0]  h;
      logic [FIFO_W-1:0] low_mask;
      h = {sop, typ, ax, strb};
      low_mask = (FIFO_W'(1) << (FIFO_W - HDR_W)) - FIFO_W'(1);
      return {h, {(FIFO_W-HDR_W){1'b0}}} | (junk() & low_mask);
   endfunction

   function automatic ax_t rand_ax(input logic [LEN_W-1:0] len);
      ax_t a;
      a.id    = ID_W'($urandom);
      a.addr  = ADDR_W'($urandom);
      a.len   = len;
      a.size  = 3'($urandom);
      a.burst = 2'($urandom);
      a.lock  = 1'($urandom);
      a.cache = 4'($urandom);
      a.prot  = 3'($urandom);
      return a;
   endfunction

   // Reference model: a write becomes len+1 beats, packed lowest slice first into words.
   task automatic send_write(input ax_t ax, input logic [STRB_W-1:0] strb,
                             input logic [DATA_W-1:0] beats[$]);
      int n;
      logic [FIFO_W-1:0] word;
      n = int'(ax.len) + 1;
      exp_aw.push_back(ax);
      for (int i = 0; i < n; i++) exp_w.push_back('{data: beats[i], strb: strb, last: (i == n - 1)});
      fifo_q.push_back(mk_hdr(8'hAA, 8'h01, ax, strb));
      for (int k = 0; k < (n + SLICES - 1) / SLICES; k++) begin
         word = junk();
         for (int j = 0; j < SLICES; j++)
            if (k * SLICES + j < n) word[j*DATA_W +: DATA_W] = beats[k * SLICES + j];
         fifo_q.push_back(word);
      end
   endtask

   task automatic rand_write(input int len);
      logic [DATA_W-1:0] bq[$];
      for (int i = 0; i <= len; i++) bq.push_back(DATA_W'($urandom));
      send_write(rand_ax(LEN_W'(len)), STRB_W'($urandom), bq);
   endtask

   task automatic send_read(input ax_t ax);
      exp_ar.push_back(ax);
      fifo_q.push_back(mk_hdr(8'hAA, 8'h02, ax, STRB_W'($urandom)));
   endtask

   task automatic send_bad(input logic [7:0] sop, input logic [7:0] typ);
      exp_err++;
      fifo_q.push_back(mk_hdr(sop, typ, rand_ax(LEN_W'($urandom)), STRB_W'($urandom)));
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while ((fifo_q.size() != 0 || exp_aw.size() != 0 || exp_ar.size() != 0 ||
              exp_w.size() != 0 || exp_err != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         fail_now(name, $sformatf("%0d words/%0d aw/%0d ar/%0d w/%0d err left, expected none",
                                  fifo_q.size(), exp_aw.size(), exp_ar.size(), exp_w.size(), exp_err));
         fifo_q.delete(); exp_aw.delete(); exp_ar.delete(); exp_w.delete(); exp_err = 0;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_pop(output int c);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.fifo_rd_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.fifo_rd_en) fail_now("pop_timeout", "no fifo_rd_en in 50 cycles");
      c = cyc;
   endtask

   // FIFO and ready driver: pops the model FIFO one cycle after an observed fifo_rd_en.
   initial begin : driver
      logic pop_now;
      bus.fifo_empty = 1'b1;
      bus.fifo_rdata = '0;
      bus.awready    = 1'b0;
      bus.wready     = 1'b0;
      bus.arready    = 1'b0;
      forever begin
         @(negedge clk);
         pop_now = bus.fifo_rd_en;
         @(posedge clk);
         #1;
         if (pop_now && fifo_q.size() > 0) bus.fifo_rdata = fifo_q.pop_front();
         bus.fifo_empty = (fifo_q.size() == 0) || (rand_mode && $urandom_range(0, 2) == 0);
         bus.awready    = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.wready     = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.arready    = ar_block ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   // Monitor: pops expectations on every handshake and checks valid/field stability.
   initial begin : monitor
      logic pv_aw, pv_ar, pv_w;
      ax_t  p_aw, p_ar, c_aw, c_ar, e_ax;
      w_t   p_w, c_w, e_w;
      pv_aw = 1'b0; pv_ar = 1'b0; pv_w = 1'b0;
      p_aw = '0; p_ar = '0; p_w = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv_aw = 1'b0; pv_ar = 1'b0; pv_w = 1'b0;
         end else begin
            c_aw = {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awprot};
            c_ar = {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot};
            c_w  = {bus.wdata, bus.wstrb, bus.wlast};
            if (bus.fifo_rd_en) chk("pop_while_empty", 256'(bus.fifo_empty), 256'(0));
            if (pv_aw) chk("aw_stable", 256'({bus.awvalid, c_aw}), 256'({1'b1, p_aw}));
            if (pv_ar) chk("ar_stable", 256'({bus.arvalid, c_ar}), 256'({1'b1, p_ar}));
            if (pv_w)  chk("w_stable",  256'({bus.wvalid, c_w}),   256'({1'b1, p_w}));
            if (bus.awvalid) begin
               if (exp_aw.size() == 0) fail_now("aw_unexpected", "awvalid=1, expected no AW");
               else if (bus.awready) begin
                  e_ax = exp_aw.pop_front();
                  chk("aw_fields", 256'(c_aw), 256'(e_ax));
                  aw_hs_cyc.push_back(cyc);
               end
            end
            if (bus.arvalid) begin
               if (exp_ar.size() == 0) fail_now("ar_unexpected", "arvalid=1, expected no AR");
               else if (bus.arready) begin
                  e_ax = exp_ar.pop_front();
                  chk("ar_fields", 256'(c_ar), 256'(e_ax));
               end
            end
            if (bus.wvalid) begin
               if (exp_w.size() == 0) fail_now("w_unexpected", "wvalid=1, expected no W");
               else if (bus.wready) begin
                  e_w = exp_w.pop_front();
                  chk("w_beat", 256'(c_w), 256'(e_w));
                  w_hs_cyc.push_back(cyc);
               end
            end
            if (bus.pkt_err) begin
               chk("pkt_err_expected", 256'(1), 256'(exp_err > 0));
               if (exp_err > 0) exp_err--;
            end
            pv_aw = bus.awvalid && !bus.awready; p_aw = c_aw;
            pv_ar = bus.arvalid && !bus.arready; p_ar = c_ar;
            pv_w  = bus.wvalid && !bus.wready;   p_w  = c_w;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish by 500000, expected earlier finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int c0, n;
      ax_t ax;
      logic [DATA_W-1:0] bq[$];

      // Reset values
      repeat (3) @(negedge clk);
      chk("reset_outputs", all_out(), 256'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Read header: t+2 latency, AR held under back-pressure
      ar_block = 1'b1;
      ax = '{id: 4'd3, addr: 32'h1000_0040, len: 8'd3, size: 3'd2, burst: 2'b01,
             lock: 1'b0, cache: 4'd0, prot: 3'd0};
      send_read(ax);
      wait_pop(c0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.arvalid && n < 10);
      chk("ar_latency", 256'(cyc - c0), 256'(2));
      repeat (5) @(negedge clk);
      chk("ar_held_valid", 256'(bus.arvalid), 256'(1));
      chk("ar_held_addr", 256'(bus.araddr), 256'(32'h1000_0040));
      ar_block = 1'b0;
      wait_drain("drain_read", 100);

      // Write len=7: beats i, two words, refill bubbles
      aw_hs_cyc.delete(); w_hs_cyc.delete();
      bq.delete();
      for (int i = 0; i < 8; i++) bq.push_back(DATA_W'(i));
      send_write(rand_ax(8'd7), 4'hF, bq);
      wait_drain("drain_write8", 200);
      if (aw_hs_cyc.size() == 1 && w_hs_cyc.size() == 8) begin
         chk("aw_to_first_w", 256'(w_hs_cyc[0] - aw_hs_cyc[0]), 256'(3));
         chk("w_full_rate",   256'(w_hs_cyc[3] - w_hs_cyc[0]),  256'(3));
         chk("w_refill_gap",  256'(w_hs_cyc[4] - w_hs_cyc[3]),  256'(3));
      end else begin
         fail_now("hs_count", $sformatf("%0d AW/%0d W handshakes, expected 1/8",
                                        aw_hs_cyc.size(), w_hs_cyc.size()));
      end

      // Write len=0 then a read decoded from the next header
      bq.delete();
      bq.push_back(32'hCAFE_0001);
      send_write(rand_ax(8'd0), 4'h5, bq);
      send_read(rand_ax(LEN_W'($urandom)));
      wait_drain("drain_len0", 200);

      // Bad SOP: pkt_err at t+1, then a read proceeds
      send_bad(8'h55, 8'h02);
      send_read(rand_ax(8'd1));
      wait_pop(c0);
      @(negedge clk);
      chk("pkt_err_t1", 256'(bus.pkt_err), 256'(1));
      wait_drain("drain_bad", 200);

      // Randomised stalls: long burst plus a random packet mix
      rand_mode = 1'b1;
      rand_write(255);
      for (int k = 0; k < 24; k++) begin
         n = $urandom_range(0, 9);
         if (n < 4) send_read(rand_ax(LEN_W'($urandom)));
         else if (n < 8) rand_write($urandom_range(0, 20));
         else if (n == 8) send_bad(8'($urandom_range(0, 169)), 8'h01);
         else send_bad(8'hAA, 8'($urandom_range(3, 255)));
      end
      wait_drain("drain_random", 20000);
      rand_mode = 1'b0;
      repeat (3) @(negedge clk);

      // Async reset in the middle of a burst, then normal decode again
      w_hs_cyc.delete();
      rand_write(15);
      n = 0;
      while (w_hs_cyc.size() < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (w_hs_cyc.size() < 5) fail_now("mid_burst_timeout", "fewer than 5 W beats");
      rst_n = 1'b0;
      #1;
      chk("reset_mid_beats", all_out(), 256'(0));
      fifo_q.delete(); exp_aw.delete(); exp_ar.delete(); exp_w.delete(); exp_err = 0;
      repeat (3) @(negedge clk);
      chk("reset_held", all_out(), 256'(0));
      rst_n = 1'b1;
      @(negedge clk);
      send_read(rand_ax(LEN_W'($urandom)));
      rand_write(2);
      wait_drain("drain_after_reset", 300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
